// File: rtl/axi_spram_pkg.sv
// rtl/axi_spram_pkg.sv - shared types and constants for the AXI-Lite to SPRAM bridge
package axi_spram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP
  } bridge_state_t;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/spram_lat_timer.sv
// rtl/spram_lat_timer.sv - load/decrement latency counter with a done flag
module spram_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on issue, then count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/axi_lite_spram_bridge.sv
// rtl/axi_lite_spram_bridge.sv - AXI4-Lite slave that issues single-cycle SPRAM accesses
module axi_lite_spram_bridge
  import axi_spram_pkg::*;
#(
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  bridge_state_t state;
  bridge_state_t state_next;

  logic             wr_cand;
  logic             rd_cand;
  logic             grant_wr;
  logic             grant_rd;
  logic             rr_write_next;
  logic             wstrb_q;
  logic             lat_load;
  logic             lat_done;
  logic [CNT_W-1:0] lat_val;

  // A write is only a candidate once address and data are both offered
  assign wr_cand = s_awvalid && s_wvalid;
  assign rd_cand = s_arvalid;

  assign lat_load = (state == ST_WR_ISSUE) || (state == ST_RD_ISSUE);
  assign lat_val  = (state == ST_WR_ISSUE) ? CNT_W'(WRITE_LATENCY - 1)
                                           : CNT_W'(READ_LATENCY - 1);

  spram_lat_timer #(
    .W(CNT_W)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (lat_val),
    .done     (lat_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant decision; reset suppresses any grant in the same cycle
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst) begin
          if (wr_cand && (!rd_cand || rr_write_next)) begin
            grant_wr   = 1'b1;
            state_next = ST_WR_ISSUE;
          end else if (rd_cand) begin
            grant_rd   = 1'b1;
            state_next = ST_RD_ISSUE;
          end
        end
      end
      ST_WR_ISSUE: state_next = ST_WR_WAIT;
      ST_WR_WAIT:  if (lat_done) state_next = ST_WR_RESP;
      ST_WR_RESP:  if (s_bready) state_next = ST_IDLE;
      ST_RD_ISSUE: state_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (lat_done) state_next = ST_RD_RESP;
      ST_RD_RESP:  if (s_rready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Handshake and RAM strobes derived from state
  always_comb begin
    s_awready = grant_wr;
    s_wready  = grant_wr;
    s_arready = grant_rd;
    s_bvalid  = (state == ST_WR_RESP);
    s_rvalid  = (state == ST_RD_RESP);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_WR_ISSUE: begin
        mem_en = wstrb_q;
        mem_we = wstrb_q;
      end
      ST_RD_ISSUE: mem_en = 1'b1;
      default: ;
    endcase
  end

  assign s_bresp = RESP_OKAY;
  assign s_rresp = RESP_OKAY;

  // Latch the granted request, flip arbitration on contention, capture read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_write_next <= 1'b1;
      wstrb_q       <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      s_rdata       <= '0;
    end else begin
      if (grant_wr) begin
        mem_addr <= s_awaddr;
        mem_din  <= s_wdata;
        wstrb_q  <= s_wstrb;
      end
      if (grant_rd) begin
        mem_addr <= s_araddr;
      end
      if ((grant_wr || grant_rd) && wr_cand && rd_cand) begin
        rr_write_next <= !rr_write_next;
      end
      if (state == ST_RD_WAIT && lat_done) begin
        s_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_spram_bridge.sv
// tb/tb_axi_lite_spram_bridge.sv - self-checking bench for the AXI-Lite SPRAM bridge
module tb_axi_lite_spram_bridge;

  localparam int NI = 3;
  localparam int LATS [NI] = '{2, 1, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       awvalid [NI];
  logic       awready [NI];
  logic [4:0] awaddr  [NI];
  logic       wvalid  [NI];
  logic       wready  [NI];
  logic [7:0] wdata   [NI];
  logic       wstrb   [NI];
  logic       bvalid  [NI];
  logic       bready  [NI];
  logic [1:0] bresp   [NI];
  logic       arvalid [NI];
  logic       arready [NI];
  logic [4:0] araddr  [NI];
  logic       rvalid  [NI];
  logic       rready  [NI];
  logic [7:0] rdata   [NI];
  logic [1:0] rresp   [NI];
  logic       mem_en  [NI];
  logic       mem_we  [NI];
  logic [4:0] mem_addr[NI];
  logic [7:0] mem_din [NI];
  logic [7:0] mem_dout[NI];

  logic [7:0] ram     [NI][32];
  logic [7:0] pipe    [NI][4];
  logic [7:0] exp_mem [NI][32];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi_lite_spram_bridge #(
      .ADDR_W(5), .DATA_W(8), .READ_LATENCY(LATS[g]), .WRITE_LATENCY(LATS[g])
    ) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(awvalid[g]), .s_awready(awready[g]), .s_awaddr(awaddr[g]),
      .s_wvalid(wvalid[g]), .s_wready(wready[g]), .s_wdata(wdata[g]), .s_wstrb(wstrb[g]),
      .s_bvalid(bvalid[g]), .s_bready(bready[g]), .s_bresp(bresp[g]),
      .s_arvalid(arvalid[g]), .s_arready(arready[g]), .s_araddr(araddr[g]),
      .s_rvalid(rvalid[g]), .s_rready(rready[g]), .s_rdata(rdata[g]), .s_rresp(rresp[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_din(mem_din[g]), .mem_dout(mem_dout[g])
    );
  end

  // SPRAM models: write at the issue edge, read data appears LAT edges later, junk otherwise
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_en[k] && mem_we[k]) ram[k][mem_addr[k]] <= mem_din[k];
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? ram[k][mem_addr[k]] : 8'($urandom);
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) mem_dout[k] = pipe[k][LATS[k]-1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_bits(input int k);
    return {awready[k], wready[k], bvalid[k], bresp[k], arready[k], rvalid[k], rresp[k],
            mem_en[k], mem_we[k], rdata[k], mem_addr[k], mem_din[k]};
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < NI; k++) begin
      awvalid[k] = 0; awaddr[k] = 0; wvalid[k] = 0; wdata[k] = 0; wstrb[k] = 0;
      bready[k] = 0; arvalid[k] = 0; araddr[k] = 0; rready[k] = 0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Full write: returns edges from handshake to bvalid, mem_en pulses, and protocol errors
  task automatic write_txn(input int k, input logic [4:0] a, input logic [7:0] d, input logic s,
                           input int stall, output int lat, output int en_n, output int bad,
                           output bit ok);
    int n;
    ok = 1; lat = 0; en_n = 0; bad = 0;
    @(negedge clk);
    awvalid[k] = 1; awaddr[k] = a; wvalid[k] = 1; wdata[k] = d; wstrb[k] = s; bready[k] = 0;
    #1;
    n = 0;
    while (!(awready[k] && wready[k]) && n < 64) begin @(negedge clk); #1; n++; end
    if (!(awready[k] && wready[k])) begin
      ok = 0; awvalid[k] = 0; wvalid[k] = 0; return;
    end
    @(posedge clk); #1;
    awvalid[k] = 0; wvalid[k] = 0;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (bvalid[k]) break;
      if (mem_en[k]) begin
        en_n++;
        if (!(mem_we[k] && mem_addr[k] == a && mem_din[k] == d)) bad++;
      end
      lat++; n++;
    end
    if (!bvalid[k]) begin ok = 0; return; end
    repeat (stall) begin @(negedge clk); if (!bvalid[k] || rvalid[k]) bad++; end
    if (bresp[k] != 2'b00) bad++;
    bready[k] = 1;
    @(posedge clk); #1;
    bready[k] = 0;
    @(negedge clk);
    if (bvalid[k]) bad++;
  endtask

  task automatic read_txn(input int k, input logic [4:0] a, input int stall,
                          output logic [7:0] d, output int lat, output int en_n,
                          output int bad, output bit ok);
    int n;
    ok = 1; lat = 0; en_n = 0; bad = 0; d = 0;
    @(negedge clk);
    arvalid[k] = 1; araddr[k] = a; rready[k] = 0;
    #1;
    n = 0;
    while (!arready[k] && n < 64) begin @(negedge clk); #1; n++; end
    if (!arready[k]) begin ok = 0; arvalid[k] = 0; return; end
    @(posedge clk); #1;
    arvalid[k] = 0;
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (rvalid[k]) break;
      if (mem_en[k]) begin
        en_n++;
        if (mem_we[k] || mem_addr[k] != a) bad++;
      end
      lat++; n++;
    end
    if (!rvalid[k]) begin ok = 0; return; end
    d = rdata[k];
    repeat (stall) begin
      @(negedge clk);
      if (!rvalid[k] || bvalid[k] || rdata[k] != d) bad++;
    end
    if (rresp[k] != 2'b00) bad++;
    rready[k] = 1;
    @(posedge clk); #1;
    rready[k] = 0;
    @(negedge clk);
    if (rvalid[k]) bad++;
  endtask

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] data;
    bit         strb;
    logic [7:0] exp_rdata;
    int         exp_en;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, en_n, bad, n, both;
    bit ok, got_r;
    logic [7:0] d, d0;
    int grants [$];

    vecs[0] = '{1, 5'd5,  8'hA5, 1, 8'h00, 1};
    vecs[1] = '{0, 5'd5,  8'h00, 0, 8'hA5, 1};
    vecs[2] = '{1, 5'd3,  8'h3C, 1, 8'h00, 1};
    vecs[3] = '{1, 5'd3,  8'hFF, 0, 8'h00, 0};
    vecs[4] = '{0, 5'd3,  8'h00, 0, 8'h3C, 1};
    vecs[5] = '{1, 5'd0,  8'h00, 1, 8'h00, 1};
    vecs[6] = '{1, 5'd31, 8'h5A, 1, 8'h00, 1};
    vecs[7] = '{0, 5'd31, 8'h00, 0, 8'h5A, 1};
    vecs[8] = '{0, 5'd0,  8'h00, 0, 8'h00, 1};

    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("reset_outputs[%0d]", k), out_bits(k), 0);
    rst = 0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("idle_outputs[%0d]", k), out_bits(k), 0);

    // Table-driven basic transactions on the default-latency instance
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        write_txn(0, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, lat, en_n, bad, ok);
        if (vecs[i].strb) exp_mem[0][vecs[i].addr] = vecs[i].data;
      end else begin
        read_txn(0, vecs[i].addr, 0, d, lat, en_n, bad, ok);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_mem_en_pulses", i), en_n, vecs[i].exp_en);
      check($sformatf("vec%0d_latency", i), lat, 1 + LATS[0]);
      check($sformatf("vec%0d_protocol", i), bad, 0);
    end

    // Contention after reset: write first, then read, then write
    pulse_reset();
    @(negedge clk);
    awvalid[0] = 1; wvalid[0] = 1; awaddr[0] = 9; wdata[0] = 8'h77; wstrb[0] = 1;
    arvalid[0] = 1; araddr[0] = 9; bready[0] = 1; rready[0] = 1;
    #1;
    n = 0; both = 0; got_r = 0; d = 0;
    grants.delete();
    while (grants.size() < 3 && n < 100) begin
      if (awready[0] && arready[0]) both++;
      if (bvalid[0] && rvalid[0]) both++;
      if (awready[0]) grants.push_back(1);
      else if (arready[0]) grants.push_back(0);
      if (rvalid[0] && !got_r) begin got_r = 1; d = rdata[0]; end
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0;
    repeat (10) begin @(negedge clk); if (bvalid[0] && rvalid[0]) both++; end
    bready[0] = 0; rready[0] = 0;
    exp_mem[0][9] = 8'h77;
    check("rr_grant_count", grants.size(), 3);
    check("rr_grant0_write", (grants.size() > 0) ? grants[0] : 2, 1);
    check("rr_grant1_read",  (grants.size() > 1) ? grants[1] : 2, 0);
    check("rr_grant2_write", (grants.size() > 2) ? grants[2] : 2, 1);
    check("rr_read_sees_write", {got_r, d}, {1'b1, 8'h77});
    check("rr_exclusive_valids", both, 0);

    // Read backpressure with other requests pending
    @(negedge clk);
    arvalid[0] = 1; araddr[0] = 5; rready[0] = 0;
    #1;
    n = 0;
    while (!arready[0] && n < 64) begin @(negedge clk); #1; n++; end
    check("bp_ar_granted", arready[0], 1);
    @(posedge clk); #1;
    awvalid[0] = 1; wvalid[0] = 1; awaddr[0] = 7; wdata[0] = 8'h11; wstrb[0] = 1;
    n = 0;
    while (!rvalid[0] && n < 64) begin @(negedge clk); n++; end
    check("bp_rvalid_arrives", rvalid[0], 1);
    d0 = rdata[0];
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rvalid[0] || rdata[0] != d0 || awready[0] || wready[0] || arready[0]) bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_rdata", d0, 8'hA5);
    awvalid[0] = 0; wvalid[0] = 0; arvalid[0] = 0; rready[0] = 1;
    @(posedge clk); #1;
    rready[0] = 0;
    @(negedge clk);
    check("bp_rvalid_released", rvalid[0], 0);

    // AW alone is held off until W joins, then both readies rise together
    @(negedge clk);
    awvalid[0] = 1; awaddr[0] = 12; wdata[0] = 8'hC3; wstrb[0] = 1; bready[0] = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (awready[0] || wready[0]) bad++;
      @(negedge clk);
    end
    check("split_aw_held", bad, 0);
    wvalid[0] = 1;
    #1;
    check("split_joint_ready", {awready[0], wready[0]}, 2'b11);
    @(posedge clk); #1;
    awvalid[0] = 0; wvalid[0] = 0;
    n = 0;
    while (!bvalid[0] && n < 64) begin @(negedge clk); n++; end
    check("split_bvalid", bvalid[0], 1);
    @(posedge clk); #1;
    bready[0] = 0;
    exp_mem[0][12] = 8'hC3;
    read_txn(0, 12, 0, d, lat, en_n, bad, ok);
    check("split_readback", d, 8'hC3);

    // Reset while a read is waiting on the RAM
    @(negedge clk);
    arvalid[0] = 1; araddr[0] = 5; rready[0] = 1;
    #1;
    n = 0;
    while (!arready[0] && n < 64) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid[0] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid_read_outputs", out_bits(0), 0);
    rst = 0;
    bad = 0;
    repeat (10) begin @(negedge clk); if (rvalid[0]) bad++; end
    check("rst_mid_read_no_rvalid", bad, 0);
    rready[0] = 0;
    read_txn(0, 5, 0, d, lat, en_n, bad, ok);
    check("rst_fresh_read", {ok, d}, {1'b1, 8'hA5});

    // Address sweep on every latency variant
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 32; i++) begin
        write_txn(k, 5'(i), 8'(i), 1, 0, lat, en_n, bad, ok);
        exp_mem[k][i] = 8'(i);
        check($sformatf("sweep%0d_wr%0d", k, i), {ok, 8'(en_n), 8'(lat), 8'(bad)},
              {1'b1, 8'd1, 8'(1 + LATS[k]), 8'd0});
      end
      for (int i = 0; i < 32; i++) begin
        read_txn(k, 5'(i), 0, d, lat, en_n, bad, ok);
        check($sformatf("sweep%0d_rd%0d", k, i), {ok, 8'(en_n), 8'(lat), 8'(bad), d},
              {1'b1, 8'd1, 8'(1 + LATS[k]), 8'd0, 8'(i)});
      end
    end

    // Random traffic against the array model, with random response stalls
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 60; t++) begin
        logic [4:0] a;
        logic [7:0] wd;
        logic       s;
        int         st;
        a  = 5'($urandom);
        wd = 8'($urandom);
        s  = ($urandom_range(0, 3) != 0);
        st = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) begin
          write_txn(k, a, wd, s, st, lat, en_n, bad, ok);
          if (s) exp_mem[k][a] = wd;
          check($sformatf("rand%0d_wr%0d", k, t), {ok, 8'(en_n), 8'(lat), 8'(bad)},
                {1'b1, 8'(s ? 1 : 0), 8'(1 + LATS[k]), 8'd0});
        end else begin
          read_txn(k, a, st, d, lat, en_n, bad, ok);
          check($sformatf("rand%0d_rd%0d", k, t), {ok, 8'(en_n), 8'(lat), 8'(bad), d},
                {1'b1, 8'd1, 8'(1 + LATS[k]), 8'd0, exp_mem[k][a]});
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
